reg_file_banked: RTL and testbench
==================================

REG_FILE_BANKED -- requirements
Module: reg_file_banked

Interface
REQ-001 Parameter DATA_W, default 16, register data width in bits.
REQ-002 Parameter NUM_REGS, default 16, number of general registers; must be a power of two and at least 2.
REQ-003 Parameter FLAG_W, default 5, flag register width in bits.
REQ-004 Parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-005 Derived AW = clog2(NUM_REGS), the address width.
REQ-006 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1, asynchronous, active-high reset.
REQ-008 Port wr_en, input, 1, write strobe.
REQ-009 Port wr_addr, input, AW, write address.
REQ-010 Port wr_data, input, DATA_W, write data.
REQ-011 Port rd_addr_a / rd_addr_b, input, AW each, read addresses for ports A and B.
REQ-012 Port rd_data_a / rd_data_b, output, DATA_W each, read data for ports A and B.
REQ-013 Port flags_en, input, 1, flag update strobe.
REQ-014 Port flags_mask, input, FLAG_W, per-bit flag update enable.
REQ-015 Port flags_in, input, FLAG_W, new flag values.
REQ-016 Port flags_out, output, FLAG_W, current flags.
REQ-017 Port save, input, 1, copy the main bank and flags into the shadow bank.
REQ-018 Port restore, input, 1, copy the shadow bank and flags into the main bank.
REQ-019 Port clear_req, input, 1, start a sequential clear of the main bank.
REQ-020 Port busy, output, 1, high while a clear is in progress.
REQ-021 Port clear_done, output, 1, one-cycle pulse when a clear completes.

Function
REQ-022 A write SHALL occur when wr_en=1 and busy=0: reg[wr_addr] <= wr_data, except address 0 when ZERO_REG=1.
REQ-023 Reads SHALL be combinational: rd_data_x = reg[rd_addr_x].
REQ-024 Reads SHALL bypass a same-cycle write: if the write is effective (REQ-022, not preempted per REQ-028) and wr_addr==rd_addr_x, rd_data_x = wr_data.
REQ-025 When ZERO_REG=1 and rd_addr_x==0, rd_data_x SHALL be 0 regardless of bypass.
REQ-026 A flag update SHALL occur when flags_en=1 and busy=0: flags <= (flags & ~flags_mask) | (flags_in & flags_mask); a zero mask leaves flags unchanged.
REQ-027 Save SHALL capture all registers and flags in one cycle, using pre-edge values; a same-cycle write or flag update lands in the main bank only.
REQ-028 Same-cycle priority SHALL be clear start > restore > save > write/flag update; restore drops same-cycle writes and flag updates.
REQ-029 save, restore and clear_req SHALL be ignored while busy=1.
REQ-030 The clear FSM SHALL use two states, IDLE and CLEAR, with an index counter idx of width AW.
REQ-031 In IDLE, clear_req=1 SHALL move the FSM to CLEAR with idx=0; busy SHALL go high on the following cycle.
REQ-032 Each CLEAR cycle SHALL zero reg[idx] and increment idx.
REQ-033 On the cycle that zeroes reg[NUM_REGS-1], the FSM SHALL also zero flags, wrap idx to 0, pulse clear_done, and return to IDLE.
REQ-034 Total busy duration SHALL be exactly NUM_REGS cycles.
REQ-035 While busy, reads SHALL return current contents with bypass disabled; the shadow bank SHALL be untouched by a clear.

Reset
REQ-036 Reset SHALL asynchronously zero all main registers, shadow registers, flags, shadow flags and idx.
REQ-037 Reset SHALL force the FSM to IDLE, busy=0 and clear_done=0.
REQ-038 Reset asserted during a clear SHALL abort it immediately; no clear_done pulse is produced.

Structure
REQ-039 Package rf_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the operation-priority constants.
REQ-040 Sub-module rf_clear_seq SHALL implement the FSM, idx counter, busy and clear_done; it outputs a clear strobe and index, and the main module owns all storage.

Verification
REQ-041 Reset, then write 0x1234 to r3, then read A=3 next cycle -> rd_data_a=0x1234; same-cycle write 0xBEEF to r5 with rd_addr_b=5 -> rd_data_b=0xBEEF.
REQ-042 ZERO_REG=1: write 0xFFFF to r0 -> rd_data_a at address 0 reads 0 both same cycle and next cycle.
REQ-043 flags=5'b10101, then flags_en with mask 5'b00011 and flags_in 5'b11110 -> flags_out=5'b10110.
REQ-044 r1=0xAAAA; save with same-cycle write r1=0x5555; then restore -> r1=0xAAAA; restore with same-cycle write r2=0x7777 -> r2 holds its shadow value.
REQ-045 clear_req with NUM_REGS=16 -> busy high 16 cycles, clear_done pulses once on the last, all registers and flags 0; writes, save and clear_req during busy have no effect.
REQ-046 Assert reset at clear cycle 7 -> busy=0 immediately, all state 0, no clear_done pulse.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared types for the banked register file.
//   clr_state_e : states of the sequential-clear FSM
//   rf_op_e     : bank-level operation chosen in a cycle. The encoding is the
//                 priority rank, so a larger value always wins.
//   pick_op     : resolves simultaneous clear/restore/save requests.
package rf_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   typedef enum logic [1:0] {
      OP_NONE    = 2'd0,   // plain write / flag update only
      OP_SAVE    = 2'd1,
      OP_RESTORE = 2'd2,
      OP_CLEAR   = 2'd3
   } rf_op_e;

   function automatic rf_op_e pick_op(input logic clear_req,
                                      input logic restore,
                                      input logic save);
      if (clear_req)    return OP_CLEAR;
      else if (restore) return OP_RESTORE;
      else if (save)    return OP_SAVE;
      else              return OP_NONE;
   endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: sequencer that walks the main bank one register per cycle.
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   clear_req_i     : start request, only acted on in IDLE
//   busy_o          : high for every CLEAR cycle (NUM_REGS cycles)
//   clear_done_o    : high on the CLEAR cycle that zeroes the last register
//   clr_en_o        : strobe telling the owner of the storage to zero clr_idx_o
//   clr_idx_o       : register being zeroed this cycle
//   state_o         : current FSM state, for observation
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter int NUM_REGS = 16,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          clear_req_i,
   output logic          busy_o,
   output logic          clear_done_o,
   output logic          clr_en_o,
   output logic [AW-1:0] clr_idx_o,
   output clr_state_e    state_o
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      busy_o       = 1'b0;
      clear_done_o = 1'b0;
      clr_en_o     = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_req_i) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            busy_o   = 1'b1;
            clr_en_o = 1'b1;
            // NUM_REGS is a power of two, so the increment wraps to 0 on the last register
            idx_d    = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               clear_done_o = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign clr_idx_o = idx_q;
   assign state_o   = state_q;

endmodule

// File: rtl/reg_file_banked.sv
// reg_file_banked: two-read/one-write register file with flags, a shadow bank
// (save/restore) and a sequential clear.
//   clk, reset                 : clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data    : write port (blocked while busy)
//   rd_addr_a/b, rd_data_a/b   : combinational read ports with write bypass
//   flags_en, flags_mask,
//   flags_in, flags_out        : masked flag update and current flags
//   save, restore              : copy main->shadow / shadow->main
//   clear_req, busy, clear_done: sequential clear of the main bank
//   clear_state                : clear FSM state, for observation
// Same-cycle priority: clear start > restore > save > write/flag update.
module reg_file_banked
   import rf_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int FLAG_W   = 5,
   parameter int ZERO_REG = 0,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              flags_en,
   input  logic [FLAG_W-1:0] flags_mask,
   input  logic [FLAG_W-1:0] flags_in,
   output logic [FLAG_W-1:0] flags_out,
   input  logic              save,
   input  logic              restore,
   input  logic              clear_req,
   output logic              busy,
   output logic              clear_done,
   output clr_state_e        clear_state
);

   localparam bit ZR = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs_q   [NUM_REGS];
   logic [DATA_W-1:0] regs_d   [NUM_REGS];
   logic [DATA_W-1:0] shadow_q [NUM_REGS];
   logic [DATA_W-1:0] shadow_d [NUM_REGS];
   logic [FLAG_W-1:0] flags_q, flags_d, sflags_q, sflags_d;

   logic          clr_en;
   logic [AW-1:0] clr_idx;
   rf_op_e        op;
   logic          wr_eff, flag_eff;

   rf_clear_seq #(.NUM_REGS(NUM_REGS)) u_clear_seq (
      .clk_i        (clk),
      .reset_i      (reset),
      .clear_req_i  (clear_req),
      .busy_o       (busy),
      .clear_done_o (clear_done),
      .clr_en_o     (clr_en),
      .clr_idx_o    (clr_idx),
      .state_o      (clear_state)
   );

   // Bank operations are ignored entirely while a clear is running.
   assign op = busy ? OP_NONE : pick_op(clear_req, restore, save);

   // Writes and flag updates coexist with save (they land in the main bank
   // only) but lose to restore and to a clear start.
   assign wr_eff   = wr_en && !busy && (op < OP_RESTORE) && !(ZR && (wr_addr == '0));
   assign flag_eff = flags_en && !busy && (op < OP_RESTORE);

   always_comb begin
      regs_d   = regs_q;
      shadow_d = shadow_q;
      flags_d  = flags_q;
      sflags_d = sflags_q;
      if (clr_en) begin
         regs_d[clr_idx] = '0;
         if (clear_done) flags_d = '0;
      end else if (op == OP_RESTORE) begin
         regs_d  = shadow_q;
         flags_d = sflags_q;
      end else begin
         if (op == OP_SAVE) begin
            shadow_d = regs_q;
            sflags_d = flags_q;
         end
         if (wr_eff)   regs_d[wr_addr] = wr_data;
         if (flag_eff) flags_d = (flags_q & ~flags_mask) | (flags_in & flags_mask);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q   <= '{default: '0};
         shadow_q <= '{default: '0};
         flags_q  <= '0;
         sflags_q <= '0;
      end else begin
         regs_q   <= regs_d;
         shadow_q <= shadow_d;
         flags_q  <= flags_d;
         sflags_q <= sflags_d;
      end
   end

   // Read ports: stored value, overridden by an effective same-cycle write,
   // overridden again by the hard-wired zero register.
   always_comb begin
      rd_data_a = regs_q[rd_addr_a];
      if (wr_eff && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      if (ZR && (rd_addr_a == '0))          rd_data_a = '0;
   end

   always_comb begin
      rd_data_b = regs_q[rd_addr_b];
      if (wr_eff && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      if (ZR && (rd_addr_b == '0))          rd_data_b = '0;
   end

   assign flags_out = flags_q;

endmodule

// File: tb/tb_reg_file_banked.sv
module tb_reg_file_banked;
   import rf_pkg::*;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;
   localparam int FLAG_W   = 5;
   localparam int AW       = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #10 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              wr_en, flags_en, save, restore, clear_req;
   logic [AW-1:0]     wr_addr, rd_addr_a, rd_addr_b;
   logic [DATA_W-1:0] wr_data;
   logic [FLAG_W-1:0] flags_mask, flags_in;

   logic [DATA_W-1:0] rd_data_a, rd_data_b, rd_data_a_z, rd_data_b_z;
   logic [FLAG_W-1:0] flags_out, flags_out_z;
   logic              busy, clear_done, busy_z, clear_done_z;
   clr_state_e        clear_state, clear_state_z;

   reg_file_banked #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .FLAG_W(FLAG_W), .ZERO_REG(0)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .flags_en(flags_en), .flags_mask(flags_mask), .flags_in(flags_in), .flags_out(flags_out),
      .save(save), .restore(restore), .clear_req(clear_req), .busy(busy),
      .clear_done(clear_done), .clear_state(clear_state)
   );

   reg_file_banked #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .FLAG_W(FLAG_W), .ZERO_REG(1)) dut_z (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a_z), .rd_data_b(rd_data_b_z),
      .flags_en(flags_en), .flags_mask(flags_mask), .flags_in(flags_in), .flags_out(flags_out_z),
      .save(save), .restore(restore), .clear_req(clear_req), .busy(busy_z),
      .clear_done(clear_done_z), .clear_state(clear_state_z)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change just after a falling edge; outputs are sampled #1 later.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      flags_en = 1'b0; flags_mask = '0; flags_in = '0;
      save = 1'b0; restore = 1'b0; clear_req = 1'b0;
   endtask

   task automatic drive_wr(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
   endtask

   task automatic drive_flags(input logic [FLAG_W-1:0] m, input logic [FLAG_W-1:0] v);
      flags_en = 1'b1; flags_mask = m; flags_in = v;
   endtask

   task automatic summary();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
   endtask

   int busy_cnt, done_cnt, done_at;

   // ---------------- stimulus ----------------
   initial begin
      idle();
      rd_addr_a = '0; rd_addr_b = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #2;
      check("rst_busy",  busy, 0);
      check("rst_done",  clear_done, 0);
      check("rst_flags", flags_out, 0);
      check("rst_state", clear_state, IDLE);
      rd_addr_a = 3; rd_addr_b = 15; #1;
      check("rst_rd_a", rd_data_a, 0);
      check("rst_rd_b", rd_data_b, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // basic write, read-next-cycle, same-cycle bypass
      drive_wr(3, 16'h1234); rd_addr_a = 3; #1;
      check("byp_a_r3", rd_data_a, 16'h1234);
      tick(); idle(); #1;
      check("rd_a_r3", rd_data_a, 16'h1234);
      tick();
      drive_wr(5, 16'hBEEF); rd_addr_b = 5; rd_addr_a = 3; #1;
      check("byp_b_r5", rd_data_b, 16'hBEEF);
      check("no_byp_a", rd_data_a, 16'h1234);
      tick(); idle(); #1;
      check("rd_b_r5", rd_data_b, 16'hBEEF);
      tick();

      // zero register: ZERO_REG=0 stores r0, ZERO_REG=1 reads 0
      drive_wr(0, 16'hFFFF); rd_addr_a = 0; #1;
      check("r0_byp",   rd_data_a,   16'hFFFF);
      check("r0z_byp",  rd_data_a_z, 16'h0000);
      tick(); idle(); rd_addr_b = 3; #1;
      check("r0_next",  rd_data_a,   16'hFFFF);
      check("r0z_next", rd_data_a_z, 16'h0000);
      check("z_r3",     rd_data_b_z, 16'h1234);
      tick();

      // masked flag update
      drive_flags(5'b11111, 5'b10101); tick(); idle(); #1;
      check("flags_set", flags_out, 5'b10101);
      tick();
      drive_flags(5'b00011, 5'b11110); tick(); idle(); #1;
      check("flags_mask", flags_out, 5'b10110);
      check("flags_mask_z", flags_out_z, 5'b10110);
      tick();
      drive_flags(5'b00000, 5'b01001); tick(); idle(); #1;
      check("flags_zero_mask", flags_out, 5'b10110);
      tick();

      // save / restore
      drive_wr(1, 16'hAAAA); tick(); idle();
      save = 1'b1; drive_wr(1, 16'h5555); tick(); idle();
      rd_addr_a = 1; #1;
      check("save_wr_main", rd_data_a, 16'h5555);
      tick();
      drive_wr(2, 16'h1111); drive_flags(5'b11111, 5'b00001); tick(); idle(); #1;
      check("flags_pre_restore", flags_out, 5'b00001);
      tick();
      restore = 1'b1; tick(); idle();
      rd_addr_a = 1; rd_addr_b = 2; #1;
      check("restore_r1", rd_data_a, 16'hAAAA);
      check("restore_r2", rd_data_b, 16'h0000);
      check("restore_flags", flags_out, 5'b10110);
      tick();
      restore = 1'b1; drive_wr(2, 16'h7777); drive_flags(5'b11111, 5'b00001); rd_addr_b = 2; #1;
      check("restore_byp_off", rd_data_b, 16'h0000);
      tick(); idle(); #1;
      check("restore_drops_wr",  rd_data_b, 16'h0000);
      check("restore_drops_flg", flags_out, 5'b10110);
      tick();
      drive_wr(4, 16'h4444); tick(); idle();
      save = 1'b1; restore = 1'b1; tick(); idle();
      rd_addr_a = 4; #1;
      check("restore_over_save", rd_data_a, 16'h0000);
      tick();

      // sequential clear; clear start preempts a same-cycle write
      clear_req = 1'b1; drive_wr(6, 16'h6666); drive_flags(5'b11111, 5'b00001); #1;
      check("clr_start_busy", busy, 0);
      tick(); idle(); #1;
      check("clr_state", clear_state, CLEAR);
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int k = 0; k < 40; k++) begin
         drive_wr(3, 16'hDEAD); rd_addr_a = 3;
         drive_flags(5'b11111, 5'b11111);
         save = 1'b1; clear_req = (k == 3); restore = (k == 9);
         #1;
         if (!busy) break;
         busy_cnt++;
         if (clear_done) begin done_cnt++; done_at = k; end
         check("busy_rd_r3", rd_data_a, (k <= 3) ? 16'h1234 : 16'h0000);
         tick();
      end
      idle();
      check("clr_busy_cycles", busy_cnt, 16);
      check("clr_done_count",  done_cnt, 1);
      check("clr_done_at",     done_at, 15);
      check("clr_end_state",   clear_state, IDLE);
      check("clr_flags",       flags_out, 0);
      tick();
      for (int a = 0; a < NUM_REGS; a++) exp_q.push_back(32'h0);
      for (int a = 0; a < NUM_REGS; a++) begin
         rd_addr_a = AW'(a); #1;
         check("clr_dump", rd_data_a, exp_q.pop_front());
         tick();
      end

      // shadow survives the clear and was not overwritten during busy
      restore = 1'b1; tick(); idle();
      rd_addr_a = 1; rd_addr_b = 3; #1;
      check("shadow_r1", rd_data_a, 16'hAAAA);
      check("shadow_r3", rd_data_b, 16'h1234);
      check("shadow_flags", flags_out, 5'b10110);
      tick();
      rd_addr_a = 0; #1;
      check("shadow_r0", rd_data_a, 16'hFFFF);
      tick();

      // reset during a clear aborts it
      drive_wr(9, 16'h9999); tick(); idle();
      clear_req = 1'b1; tick(); idle();
      repeat (7) tick();
      rd_addr_a = 9; #1;
      check("abort_pre_busy", busy, 1);
      check("abort_pre_r9",   rd_data_a, 16'h9999);
      reset = 1'b1; #1;
      check("abort_busy",  busy, 0);
      check("abort_done",  clear_done, 0);
      check("abort_state", clear_state, IDLE);
      check("abort_flags", flags_out, 0);
      check("abort_r9",    rd_data_a, 0);
      tick(); #1;
      check("abort_done_hold", clear_done, 0);
      reset = 1'b0;
      tick();
      restore = 1'b1; tick(); idle();
      rd_addr_a = 1; #1;
      check("abort_shadow_r1", rd_data_a, 0);
      check("abort_shadow_flags", flags_out, 0);
      tick();

      // a fresh clear after the abort runs its full length
      clear_req = 1'b1; tick(); idle();
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (!busy) break;
         busy_cnt++;
         if (clear_done) begin done_cnt++; done_at = k; end
         tick();
      end
      check("clr2_busy_cycles", busy_cnt, 16);
      check("clr2_done_count",  done_cnt, 1);
      check("clr2_done_at",     done_at, 15);

      summary();
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      summary();
      $finish;
   end

endmodule
